// File: rtl/trace_pkg.sv
// Shared types and field widths for the pipeline trace path: shadow slots and retirement records.
package trace_pkg;

  localparam int unsigned PcW    = 16;
  localparam int unsigned InstrW = 16;
  localparam int unsigned RegW   = 4;
  localparam int unsigned DataW  = 16;
  localparam int unsigned SeqW   = 16;
  localparam int unsigned CycW   = 32;
  localparam int unsigned StallW = 4;

  typedef struct packed {
    logic              valid;
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
    logic [CycW-1:0]   fetch_cyc;
    logic [StallW-1:0] stalls;
  } slot_t;

  typedef struct packed {
    logic [SeqW-1:0]   seq;
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
    logic [CycW-1:0]   fetch_cyc;
    logic [CycW-1:0]   retire_cyc;
    logic [StallW-1:0] stalls;
    logic              wb_we;
    logic [RegW-1:0]   wb_reg;
    logic [DataW-1:0]  wb_data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; head is read straight from the storage flops, so it is stable
// until popped. A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trace_rec_t push_rec,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output trace_rec_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_en, pop_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_rec;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_trace_emitter.sv
// Shadow tracker for the 5-stage CPU: follows each fetched instruction through D/X/M/W and
// emits one retirement record per committed instruction through a buffered valid/ready stream.
module pipeline_trace_emitter
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CYC_W   = CycW,
  parameter int unsigned STALL_W = StallW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [PcW-1:0]     if_pc,
  input  logic [InstrW-1:0]  if_instr,
  input  logic               stall,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [RegW-1:0]    wb_reg,
  input  logic [DataW-1:0]   wb_data,
  input  logic               rec_ready,
  output logic               rec_valid,
  output logic [SeqW-1:0]    rec_seq,
  output logic [PcW-1:0]     rec_pc,
  output logic [InstrW-1:0]  rec_instr,
  output logic [CYC_W-1:0]   rec_fetch_cyc,
  output logic [CYC_W-1:0]   rec_retire_cyc,
  output logic [STALL_W-1:0] rec_stalls,
  output logic               rec_wb_we,
  output logic [RegW-1:0]    rec_wb_reg,
  output logic [DataW-1:0]   rec_wb_data,
  output logic [15:0]        dropped,
  output logic               overflow
);

  localparam logic [STALL_W-1:0] StallMax = {STALL_W{1'b1}};

  logic [CYC_W-1:0] cyc_q;
  logic [SeqW-1:0]  seq_q;
  logic [15:0]      dropped_q;
  logic             overflow_q;
  slot_t            d_q, x_q, m_q, w_q;
  slot_t            d_d, x_d, m_d, w_d;

  trace_rec_t rec_in, head;
  logic       retire, pop, full, empty, drop;

  always_comb begin
    d_d = d_q;
    x_d = d_q;
    m_d = x_q;
    w_d = m_q;
    if (stall) begin
      // D holds and accrues stall time; a bubble enters X while M and W keep draining.
      x_d = '0;
      if (d_q.valid && d_q.stalls != StallMax) d_d.stalls = d_q.stalls + 1'b1;
    end else if (if_valid && !flush) begin
      d_d = '{valid: 1'b1, pc: if_pc, instr: if_instr, fetch_cyc: cyc_q, stalls: '0};
    end else begin
      d_d = '0;
    end
  end

  assign retire = w_q.valid;
  assign pop    = rec_valid && rec_ready;
  assign drop   = retire && full && !pop;

  always_comb begin
    rec_in            = '0;
    rec_in.seq        = seq_q;
    rec_in.pc         = w_q.pc;
    rec_in.instr      = w_q.instr;
    rec_in.fetch_cyc  = w_q.fetch_cyc;
    rec_in.retire_cyc = cyc_q;
    rec_in.stalls     = w_q.stalls;
    rec_in.wb_we      = wb_we;
    rec_in.wb_reg     = wb_reg;
    rec_in.wb_data    = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      seq_q      <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      d_q        <= '0;
      x_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      d_q   <= d_d;
      x_q   <= x_d;
      m_q   <= m_d;
      w_q   <= w_d;
      // Sequence advances even on a drop so consumers can see the gap.
      if (retire) seq_q <= seq_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (retire),
    .push_rec(rec_in),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign rec_valid      = !empty;
  assign rec_seq        = head.seq;
  assign rec_pc         = head.pc;
  assign rec_instr      = head.instr;
  assign rec_fetch_cyc  = head.fetch_cyc;
  assign rec_retire_cyc = head.retire_cyc;
  assign rec_stalls     = head.stalls;
  assign rec_wb_we      = head.wb_we;
  assign rec_wb_reg     = head.wb_reg;
  assign rec_wb_data    = head.wb_data;
  assign dropped        = dropped_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/pipeline_trace_emitter.md
# pipeline_trace_emitter

Synthesizable shadow tracker that runs alongside the 5-stage WISC-S25 CPU pipeline. It tags every fetched instruction, follows it through the decode, execute, memory and writeback stages under stall and flush, and emits one packed retirement record per committed instruction. Records leave through a valid/ready stream buffered in a small FIFO. The block is the producer end of the pipeline-trace path: logging and monitor consumers drain its stream.

## Interface
- DEPTH, 8: record FIFO entries (power of two, ≥2)
- CYC_W, 32: cycle-stamp width
- STALL_W, 4: per-instruction stall counter width (saturating)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch stage presents an instruction this cycle
- if_pc  in  16  PC of fetched instruction
- if_instr  in  16  fetched instruction word
- stall  in  1  CPU holds IF and ID; bubble enters EX
- flush  in  1  squash the instruction in IF this cycle (taken branch resolved in ID)
- wb_we  in  1  writeback register write enable
- wb_reg  in  4  writeback destination register
- wb_data  in  16  writeback data
- rec_ready  in  1  consumer accepts head record
- rec_valid  out  1  head record valid
- rec_seq  out  16  retirement sequence number
- rec_pc, rec_instr  out  16 each  PC and instruction word of the retired instruction
- rec_fetch_cyc, rec_retire_cyc  out  CYC_W each  fetch and retire cycle stamps
- rec_stalls  out  STALL_W  stall cycles spent in D
- rec_wb_we, rec_wb_reg, rec_wb_data  out  1/4/16  writeback effect
- dropped  out  16  count of records lost to a full FIFO (saturating)
- overflow  out  1  sticky: at least one record was dropped

## Operation
- Free-running cycle counter `cyc`: 0 in the first cycle after reset, +1 per cycle, wraps modulo 2^CYC_W.
- Four shadow slots D, X, M, W. Each holds valid, pc, instr, fetch_cyc and stalls.
- Capture: if if_valid, !stall and !flush, D loads {1, if_pc, if_instr, cyc, 0}. If !stall and the capture condition is false, D loads invalid.
- Stall: D holds its contents. If D is valid, its stalls field increments, saturating at 2^STALL_W−1. X loads invalid (bubble). M←X and W←M still advance.
- No stall: X←D, M←X, W←M.
- Flush: prevents capture only. Instructions already in D, X and M are unaffected. With flush and stall both asserted, D holds.
- Retire: when W is valid in a cycle, a record is built from W, {wb_we, wb_reg, wb_data} sampled that cycle, retire_cyc = cyc, seq = seq_ctr. seq_ctr then increments (wraps at 16 bits). seq_ctr increments even when the record is dropped, so a gap in rec_seq exposes the loss.
- FIFO push occurs on retire. Pop occurs when rec_valid && rec_ready. Records leave in retirement order.
- If the FIFO is full with no pop that cycle, the push is dropped, dropped increments (saturating at 0xFFFF) and overflow is set. If a push and a pop coincide while full, the push is accepted.
- Output fields are undefined-but-stable while rec_valid=0. Fields hold stable while rec_valid && !rec_ready.

## Timing
- Reset: all slots invalid, FIFO empty, cyc=0, seq_ctr=0, dropped=0, overflow=0, rec_valid=0, all rec_* fields 0.
- Stall-free latency: instruction fetched in cycle N has D valid in N+1, X in N+2, M in N+3, W in N+4. Its record has retire_cyc=N+4 and rec_valid=1 in N+5 (FIFO registered, one cycle).
- Each stall cycle while the instruction sits in D adds one cycle to both retire_cyc and rec_stalls.
- Peak throughput is one record per cycle in and out. rec_valid remains asserted back-to-back while the FIFO is non-empty.
- rst asserted mid-operation: all in-flight instructions and queued records are discarded the next cycle, and no partial record is emitted.

## Structure
- `trace_pkg` holds `slot_t` (valid, pc, instr, fetch_cyc, stalls), `trace_rec_t` (seq, pc, instr, fetch_cyc, retire_cyc, stalls, wb_we, wb_reg, wb_data) and the width constants for PC, instruction and register fields.
- Sub-module `trace_fifo`: parameterized synchronous FIFO of `trace_rec_t` with push, pop, full, empty and registered head output.
- The top level contains the shadow slots, cycle and sequence counters, and drop accounting.

## Test plan
- Reset, then if_valid for one cycle at cyc=2 with pc=0x0000, instr=0xA123, wb_we=1, wb_reg=3, wb_data=0x0042 at retire, rec_ready=1 → exactly one record in cyc=7 with seq=0, fetch_cyc=2, retire_cyc=6, stalls=0 and wb fields as driven.
- Instruction at pc=0x0010 fetched at cyc=4, with stall held for 2 cycles while it is in D → retire_cyc=10, stalls=2. The next instruction is fetched no earlier than cyc=7 and retires at ≥11 with seq=1.
- Three consecutive fetches at pc 0x0020/0x0022/0x0024, with flush on the 0x0022 cycle → two records only: pc 0x0020 seq 0 and pc 0x0024 seq 1.
- DEPTH=8, rec_ready=0, 10 back-to-back retirements → dropped=2, overflow=1. Raising rec_ready drains seq 0–7 in order. The next retirement carries seq=10.
- FIFO full, with rec_ready=1 in the same cycle as a retirement → no drop, dropped unchanged, record emitted after the prior 8.
- Three instructions in flight, rst pulsed for one cycle → no records emitted afterward. The first new fetch yields seq=0 with fetch_cyc counted from the new reset.
